// File: rtl/psdsqrt_pkg.sv
// psdsqrt_pkg: shared state encoding and rounding-mode constants for the square-root unit
package psdsqrt_pkg;
    typedef enum logic [1:0] {IDLE, CALC, ROUND, DONE} state_t;
    typedef enum logic [1:0] {
        RND_TRUNC     = 2'd0,
        RND_HALF_UP   = 2'd1,
        RND_HALF_EVEN = 2'd2,
        RND_CEIL      = 2'd3
    } rnd_t;
endpackage

// File: rtl/psdsqrt_if.sv
// psdsqrt_if: operand/result valid-ready bundle between producer, unit and consumer
interface psdsqrt_if #(parameter int NBITS = 32, parameter int FRAC = 4);
    logic in_valid, in_ready, out_valid, out_ready, exact, sat;
    logic [NBITS-1:0] xin;
    logic [1:0] mode;
    logic [NBITS/2-1:0] sqrt;
    logic [FRAC-1:0] frac;
    modport master (output in_valid, xin, mode, out_ready,
                    input in_ready, out_valid, sqrt, frac, exact, sat);
    modport slave (input in_valid, xin, mode, out_ready,
                   output in_ready, out_valid, sqrt, frac, exact, sat);
endinterface

// File: rtl/psdsqrt_round.sv
// psdsqrt_round: rounds the fixed-point root to an integer and saturates on overflow
module psdsqrt_round import psdsqrt_pkg::*; #(
    parameter int NBITS = 32,
    parameter int FRAC = 4
) (
    input  logic [NBITS/2+FRAC-1:0] a,
    input  logic                    ex,
    input  rnd_t                    mode_q,
    output logic [NBITS/2-1:0]      sqrt,
    output logic                    sat
);
    localparam int H = NBITS/2;
    localparam logic [FRAC-1:0] HALF = FRAC'(1) << (FRAC-1);
    logic [H-1:0] i;
    logic [FRAC-1:0] f;
    logic inc;
    logic [H:0] sum;
    always_comb begin
        i = a[H+FRAC-1:FRAC];
        f = a[FRAC-1:0];
        inc = mode_q == RND_HALF_UP   ? f >= HALF :
              mode_q == RND_HALF_EVEN ? (f > HALF || (f == HALF && i[0])) :
              mode_q == RND_CEIL      ? (f != '0 || !ex) : 1'b0;
        sum = {1'b0, i} + {{H{1'b0}}, inc};
        sat = sum[H];
        sqrt = sat ? '1 : sum[H-1:0];
    end
endmodule

// File: rtl/psdsqrt_seq.sv
// psdsqrt_seq: self-sequencing bit-serial square root, one root bit per cycle, with rounding
module psdsqrt_seq import psdsqrt_pkg::*; #(
    parameter int NBITS = 32,
    parameter int FRAC = 4
) (
    input logic clock,
    input logic reset,
    psdsqrt_if.slave bus
);
    localparam int W = NBITS + 2*FRAC;
    localparam int R = NBITS/2 + FRAC;
    state_t state;
    rnd_t mode_q;
    logic [W-1:0] reg_x, tt, aa;
    logic [R-1:0] a, b, t;
    logic [NBITS/2-1:0] sqrt_n;
    logic ex, sat_n;
    assign t = a | b;
    assign tt = W'(t) * W'(t);
    assign aa = W'(a) * W'(a);
    assign ex = reg_x == aa;
    assign bus.in_ready = state == IDLE;
    psdsqrt_round #(.NBITS(NBITS), .FRAC(FRAC)) u_round (
        .a(a), .ex(ex), .mode_q(mode_q), .sqrt(sqrt_n), .sat(sat_n)
    );
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= IDLE;
            mode_q <= RND_TRUNC;
            reg_x <= '0;
            a <= '0;
            b <= '0;
            bus.out_valid <= 1'b0;
            bus.sqrt <= '0;
            bus.frac <= '0;
            bus.exact <= 1'b0;
            bus.sat <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.in_valid) begin
                    reg_x <= {bus.xin, {2*FRAC{1'b0}}};
                    mode_q <= rnd_t'(bus.mode);
                    a <= '0;
                    b <= R'(1) << (R-1);
                    state <= CALC;
                end
                CALC: begin
                    if (reg_x >= tt) a <= t;
                    b <= b >> 1;
                    if (b[0]) state <= ROUND;
                end
                ROUND: begin
                    bus.sqrt <= sqrt_n;
                    bus.frac <= a[FRAC-1:0];
                    bus.exact <= ex;
                    bus.sat <= sat_n;
                    bus.out_valid <= 1'b1;
                    state <= DONE;
                end
                DONE: if (bus.out_ready) begin
                    bus.out_valid <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: doc/psdsqrt_seq.md
# psdsqrt_seq

Self-sequencing, parametrised fixed-point square-root unit with valid/ready handshakes and selectable rounding. It replaces the externally sequenced start/stop square-root core: it latches an operand, runs its own bit-serial digit recurrence, rounds the result, and holds it until the consumer takes it. It sits between any NBITS-wide operand producer and a streaming consumer in the datapath.

## Interface
- NBITS, 32, operand width; even, ≥ 4
- FRAC, 4, internal fractional bits of the root; ≥ 1
- Derived: W = NBITS + 2*FRAC (internal radicand width), R = NBITS/2 + FRAC (internal root width and iteration count)

- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-low reset
- in_valid  in  1  operand valid
- in_ready  out  1  unit idle, will accept operand
- xin  in  NBITS  unsigned integer operand
- mode  in  2  rounding mode, sampled with xin: 0 truncate, 1 half-up, 2 half-even, 3 ceiling
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- sqrt  out  NBITS/2  rounded integer root
- frac  out  FRAC  raw fractional root bits before rounding
- exact  out  1  xin is a perfect square at FRAC resolution (no remainder)
- sat  out  1  rounding overflowed NBITS/2 bits; sqrt saturated

## Operation
- FSM states: IDLE, CALC, ROUND, DONE.
- IDLE: in_ready=1. On in_valid: reg_x <= xin << 2*FRAC (W bits), mode_q <= mode, A <= 0, B <= 1<<(R-1), go CALC.
- CALC, one bit per cycle, MSB first: T = A|B; if reg_x ≥ T*T (full W-bit product), A <= T; B <= B>>1. After the cycle where B==1 was processed, go ROUND. Exactly R cycles in CALC.
- ROUND: I = A >> FRAC, f = A[FRAC-1:0], h = 1<<(FRAC-1), ex = (reg_x == A*A). Increment I when: mode 0 never; mode 1 f ≥ h; mode 2 f > h, or f == h and I[0]==1; mode 3 f≠0 or !ex. If increment overflows NBITS/2 bits: sqrt = all ones, sat=1. Register sqrt, frac=f, exact=ex, sat; go DONE.
- DONE: out_valid=1, outputs stable. On out_ready: go IDLE, out_valid drops next cycle. Outputs keep last values until next ROUND.
- in_valid outside IDLE is ignored (in_ready=0); xin/mode changes mid-operation have no effect.
- Half-even tie is decided on the truncated FRAC bits only (f == h exactly).

## Timing
- Accept edge = edge with in_valid & in_ready. State CALC after it; ROUND after accept+R; out_valid high after accept+R+1 edges. NBITS=32, FRAC=4: out_valid 21 cycles after accept.
- Minimum period between accepts: R+3 cycles (out_ready held high).
- Reset (reset==0 at an edge): state IDLE, in_ready=1 from that edge, out_valid=0, sqrt=0, frac=0, exact=0, sat=0, internal A/B/reg_x=0. Reset mid-CALC or in DONE discards the operation; no out_valid follows.
- out_valid and outputs are registered; in_ready decoded from state only (no combinational path from out_ready).

## Structure
- Package psdsqrt_pkg: state encoding (IDLE, CALC, ROUND, DONE) and rounding-mode constants (RND_TRUNC=0, RND_HALF_UP=1, RND_HALF_EVEN=2, RND_CEIL=3).
- Sub-module psdsqrt_round: combinational rounding/saturation (inputs A, ex, mode_q; outputs sqrt, sat), instantiated in ROUND path; parametrised by NBITS, FRAC.

## Test plan
- NBITS=32, FRAC=4, xin=16, mode 0 -> sqrt=4, frac=0, exact=1, sat=0, out_valid exactly 21 cycles after accept.
- xin=2 in modes 0/1/2/3 -> frac=0x6; sqrt=1/1/1/2, exact=0.
- xin=43 (root 6.5 truncated, f=0x8) modes 0/1/2/3 -> sqrt=6/7/6/7; xin=31 (f=0x9) mode 2 -> sqrt=6.
- xin=0xFFFFFFFF: mode 0 -> sqrt=0xFFFF, frac=0xF, sat=0; mode 1 -> sqrt=0xFFFF, sat=1. xin=0 -> sqrt=0, exact=1.
- Backpressure: out_ready low 10 cycles -> outputs stable, in_ready=0, second in_valid ignored; out_ready high -> IDLE next cycle, then new accept.
- reset=0 for one cycle mid-CALC (cycle 8) -> all outputs 0, in_ready=1, no out_valid; next operand xin=81 -> sqrt=9, exact=1.
